// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter sharing one slave bus, one transaction per grant.
// Define ARB_TIMEOUT_EN to build the watchdog that ends hung accesses with err.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_rd_req,
  input  logic        m0_wr_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_rd_req,
  input  logic        m1_wr_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        s_rd_req,
  output logic        s_wr_req,
  output logic [31:0] s_w_addr,
  output logic [31:0] s_r_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  input  logic        s_ack,
  output logic [1:0]  grant
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range");
  end

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state;
  logic        owner;
  logic        last_grant;
  logic        req0;
  logic        req1;
  logic        pick;
  logic        busy;
  logic        expire;
  logic        done;
  logic        own_rd;
  logic        own_wr;
  logic [31:0] own_addr;
  logic [31:0] own_wdata;
  logic [3:0]  own_wstrb;
  logic [31:0] rsp_data;

  assign req0 = m0_rd_req | m0_wr_req;
  assign req1 = m1_rd_req | m1_wr_req;
  // On a tie the master that did not own the bus last wins.
  assign pick = req1 & (~req0 | ~last_grant);
  assign busy = (state == BUSY);

  assign own_rd    = owner ? m1_rd_req : m0_rd_req;
  assign own_wr    = owner ? m1_wr_req : m0_wr_req;
  assign own_addr  = owner ? m1_addr   : m0_addr;
  assign own_wdata = owner ? m1_wdata  : m0_wdata;
  assign own_wstrb = owner ? m1_wstrb  : m0_wstrb;

  assign s_wr_req = busy & own_wr;
  assign s_rd_req = busy & own_rd & ~own_wr;
  assign s_w_addr = busy ? own_addr : '0;
  assign s_r_addr = busy ? own_addr : '0;
  assign s_wdata  = busy ? own_wdata : '0;
  assign s_wstrb  = busy ? own_wstrb : '0;

  assign done     = busy & (s_ack | expire);
  assign rsp_data = (s_ack && !own_wr) ? s_rdata : '0;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  assign expire = busy && (cnt == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst || !busy) begin
      cnt <= '0;
    end else if (!s_ack && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

  // A late s_ack in the expiry cycle still wins over the watchdog.
  always_ff @(posedge clk) begin
    if (rst || state == RESP) begin
      m0_err <= 1'b0;
      m1_err <= 1'b0;
    end else if (done) begin
      m0_err <= !owner && !s_ack;
      m1_err <= owner && !s_ack;
    end
  end
`else
  assign expire = 1'b0;
  assign m0_err = 1'b0;
  assign m1_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      grant      <= 2'b00;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner      <= pick;
            last_grant <= pick;
            grant      <= {pick, ~pick};
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (done) begin
            state <= RESP;
            grant <= 2'b00;
            if (owner) begin
              m1_ack   <= 1'b1;
              m1_rdata <= rsp_data;
            end else begin
              m0_ack   <= 1'b1;
              m0_rdata <= rsp_data;
            end
          end
        end
        RESP: begin
          state    <= IDLE;
          m0_ack   <= 1'b0;
          m1_ack   <= 1'b0;
          m0_rdata <= '0;
          m1_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed scenarios plus random traffic.
// The timeout scenario runs only when ARB_TIMEOUT_EN is defined.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_rd_req, m0_wr_req;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_wstrb;
  logic        m0_ack, m0_err;
  logic        m1_rd_req, m1_wr_req;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_wstrb;
  logic        m1_ack, m1_err;
  logic        s_rd_req, s_wr_req;
  logic [31:0] s_w_addr, s_r_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        s_ack;
  logic [1:0]  grant;

  logic        ack_auto, ack_man;
  logic [31:0] rdata_auto, rdata_man;
  assign s_ack   = ack_auto | ack_man;
  assign s_rdata = rdata_auto | rdata_man;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .m0_rd_req(m0_rd_req), .m0_wr_req(m0_wr_req),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
    .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_rd_req(m1_rd_req), .m1_wr_req(m1_wr_req),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
    .m1_ack(m1_ack), .m1_err(m1_err),
    .s_rd_req(s_rd_req), .s_wr_req(s_wr_req),
    .s_w_addr(s_w_addr), .s_r_addr(s_r_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rdata(s_rdata), .s_ack(s_ack),
    .grant(grant)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [1:0]  glog[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] smem[logic [31:0]];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int gcyc = 0;
  int fixed_delay = 0;
  bit slave_en = 1;
  int others[2];
  logic [1:0] prev_grant = 2'b00;
  int lat, lat0, lat1;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "bench stuck");
  end

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", n, a, e, $time);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a,
                                         input bit slave);
    if (slave) return smem.exists(a) ? smem[a] : 32'h0;
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic bit reqm(input int i);
    return (i == 0) ? (m0_rd_req | m0_wr_req) : (m1_rd_req | m1_wr_req);
  endfunction

  // Reference: a write returns zeros, a read returns the model memory
  // after all earlier transactions of that master; rd+wr acts as write.
  function automatic void predict(input int m, input bit rd, input bit wr,
                                  input logic [31:0] a,
                                  input logic [31:0] d,
                                  input logic [3:0] s);
    exp_t e;
    logic [31:0] v;
    e.err = 1'b0;
    e.rdata = 32'h0;
    if (wr) begin
      v = rd_mem(a, 0);
      for (int b = 0; b < 4; b++)
        if (s[b]) v[b*8 +: 8] = d[b*8 +: 8];
      ref_mem[a] = v;
    end else if (rd) begin
      e.rdata = rd_mem(a, 0);
    end
    if (m == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  task automatic set_m(input int m, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    if (m == 0) begin
      m0_rd_req = rd; m0_wr_req = wr;
      m0_addr = a; m0_wdata = d; m0_wstrb = s;
    end else begin
      m1_rd_req = rd; m1_wr_req = wr;
      m1_addr = a; m1_wdata = d; m1_wstrb = s;
    end
  endtask

  // Called #1 after a rising edge; returns request-to-ack cycles.
  task automatic drive(input int m, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output int l);
    int c0;
    bit got;
    set_m(m, rd, wr, a, d, s);
    c0 = cyc;
    got = 0;
    l = -1;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (((m == 0) ? m0_ack : m1_ack) === 1'b1) begin
        got = 1;
        l = cyc - c0;
      end
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL m%0d_ack_wait: got no ack want ack within 300", m);
    end
    @(posedge clk);
    #1;
    set_m(m, 0, 0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic rand_master(input int m, input int n, input int maxgap);
    int g, op, l;
    bit rd, wr;
    logic [31:0] a, d;
    logic [3:0] s;
    for (int i = 0; i < n; i++) begin
      g = $urandom_range(0, maxgap);
      repeat (g) @(posedge clk);
      if (g > 0) #1;
      op = $urandom_range(0, 2);
      rd = (op != 1);
      wr = (op != 0);
      a = ((m == 0) ? 32'h1000_0000 : 32'h2000_0000)
          | (32'($urandom_range(0, 15)) << 2);
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      predict(m, rd, wr, a, d, s);
      drive(m, rd, wr, a, d, s, l);
    end
  endtask

  task automatic chk_quiet();
    @(negedge clk);
    chk("quiet_ctrl", {m0_ack, m0_err, m1_ack, m1_err,
                       s_rd_req, s_wr_req, grant, s_wstrb}, 64'h0);
    chk("quiet_m_rdata", {m0_rdata, m1_rdata}, 64'h0);
    chk("quiet_s_addr", {s_w_addr, s_r_addr}, 64'h0);
    chk("quiet_s_wdata", s_wdata, 64'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
  endtask

  // Slave model: waits fixed_delay (or random) BUSY cycles, then acks.
  initial begin : slave
    bit in_txn;
    int left;
    logic [69:0] cap;
    logic [31:0] v;
    in_txn = 0;
    left = 0;
    cap = '0;
    ack_auto = 0;
    rdata_auto = 0;
    forever begin
      @(negedge clk);
      ack_auto = 0;
      rdata_auto = 0;
      if (rst || !(s_rd_req || s_wr_req)) begin
        in_txn = 0;
      end else if (slave_en) begin
        if (!in_txn) begin
          in_txn = 1;
          cap = {s_rd_req, s_wr_req, s_w_addr, s_wdata, s_wstrb};
          left = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 4);
        end else begin
          chk("s_hold_ctl", cap[69:68], {s_rd_req, s_wr_req});
          chk("s_hold_addr", cap[67:36], s_w_addr);
          chk("s_hold_data", {cap[35:0]}, {s_wdata, s_wstrb});
        end
        chk("s_addr_pair", s_r_addr, s_w_addr);
        if (left == 0) begin
          ack_auto = 1;
          in_txn = 0;
          if (s_wr_req) begin
            v = rd_mem(s_w_addr, 1);
            for (int b = 0; b < 4; b++)
              if (s_wstrb[b]) v[b*8 +: 8] = s_wdata[b*8 +: 8];
            smem[s_w_addr] = v;
          end else begin
            rdata_auto = rd_mem(s_r_addr, 1);
          end
        end else begin
          left--;
        end
      end
    end
  end

  // Monitor: scoreboard pops, bus invariants, grant log and fairness.
  always @(negedge clk) begin
    exp_t e;
    int j;
    if (!rst) begin
      if (m0_ack) begin
        if (q0.size() == 0) begin
          chk("m0_unexpected_ack", 1, 0);
        end else begin
          e = q0.pop_front();
          chk("m0_rdata", m0_rdata, e.rdata);
          chk("m0_err", m0_err, e.err);
        end
      end else begin
        chk("m0_nonowner_out", {m0_err, m0_rdata}, 64'h0);
      end
      if (m1_ack) begin
        if (q1.size() == 0) begin
          chk("m1_unexpected_ack", 1, 0);
        end else begin
          e = q1.pop_front();
          chk("m1_rdata", m1_rdata, e.rdata);
          chk("m1_err", m1_err, e.err);
        end
      end else begin
        chk("m1_nonowner_out", {m1_err, m1_rdata}, 64'h0);
      end
      chk("dual_ack", m0_ack & m1_ack, 0);
      chk("grant_onehot", grant == 2'b11, 0);
      chk("s_req_both", s_rd_req & s_wr_req, 0);
      chk("s_req_no_grant", (s_rd_req | s_wr_req) && grant == 2'b00, 0);
      if (grant != 2'b00) gcyc++;
      for (int i = 0; i < 2; i++)
        if (!reqm(i)) others[i] = 0;
      if (grant != 2'b00 && prev_grant == 2'b00) begin
        glog.push_back(grant);
        j = grant[1] ? 1 : 0;
        others[j] = 0;
        if (reqm(1 - j)) begin
          others[1 - j]++;
          chk("fair_wait", others[1 - j] > 1, 0);
        end
      end
    end
    prev_grant = grant;
  end

  initial begin
    ack_man = 0;
    rdata_man = 0;
    others[0] = 0;
    others[1] = 0;
    set_m(0, 0, 0, 32'h0, 32'h0, 4'h0);
    set_m(1, 0, 0, 32'h0, 32'h0, 4'h0);
    do_reset();
    chk_quiet();

    // Single read, ack in the first BUSY cycle.
    smem[32'h100] = 32'hDEAD_BEEF;
    ref_mem[32'h100] = 32'hDEAD_BEEF;
    fixed_delay = 0;
    glog.delete();
    gcyc = 0;
    predict(0, 1, 0, 32'h100, 32'h0, 4'hF);
    drive(0, 1, 0, 32'h100, 32'h0, 4'hF, lat);
    chk("single_lat", lat, 2);
    chk("single_gcyc", gcyc, 1);
    chk("single_glog_n", glog.size(), 1);
    if (glog.size() > 0) chk("single_grant", glog[0], 2'b01);

    // Tie straight out of reset: M0 first, M1 right after the turnaround.
    do_reset();
    chk_quiet();
    glog.delete();
    predict(0, 0, 1, 32'hC000_0004, 32'hA5A5_1234, 4'hF);
    predict(1, 1, 0, 32'hC000_0004, 32'h0, 4'hF);
    fork
      drive(0, 0, 1, 32'hC000_0004, 32'hA5A5_1234, 4'hF, lat0);
      drive(1, 1, 0, 32'hC000_0004, 32'h0, 4'hF, lat1);
    join
    chk("tie_m0_lat", lat0, 2);
    chk("tie_m1_lat", lat1, 5);
    chk("tie_glog_n", glog.size(), 2);
    if (glog.size() >= 2) begin
      chk("tie_first", glog[0], 2'b01);
      chk("tie_second", glog[1], 2'b10);
    end

    // Continuous contention alternates owners.
    fixed_delay = -1;
    glog.delete();
    fork
      rand_master(0, 3, 0);
      rand_master(1, 3, 0);
    join
    chk("rr_glog_n", glog.size(), 6);
    for (int k = 0; k < glog.size() && k < 6; k++)
      chk("rr_seq", glog[k], (k % 2 == 0) ? 2'b01 : 2'b10);

    // Wait states with a partial write, then read it back.
    fixed_delay = 5;
    predict(1, 0, 1, 32'h2000_0100, 32'h1122_3344, 4'b0011);
    drive(1, 0, 1, 32'h2000_0100, 32'h1122_3344, 4'b0011, lat);
    chk("wait_lat", lat, 7);
    fixed_delay = 0;
    predict(1, 1, 0, 32'h2000_0100, 32'h0, 4'hF);
    drive(1, 1, 0, 32'h2000_0100, 32'h0, 4'hF, lat);
    chk("readback_lat", lat, 2);

`ifdef ARB_TIMEOUT_EN
    // Unacknowledged access is completed by the watchdog.
    slave_en = 0;
    q0.push_back('{rdata: 32'h0, err: 1'b1});
    drive(0, 1, 0, 32'hB000_0000, 32'h0, 4'hF, lat);
    chk("timeout_lat", lat, 6);
    slave_en = 1;
    predict(1, 1, 0, 32'h2000_0040, 32'h0, 4'hF);
    drive(1, 1, 0, 32'h2000_0040, 32'h0, 4'hF, lat);
    chk("post_timeout_lat", lat, 2);
`endif

    // Reset while M1's read is stalled, then a stray s_ack.
    slave_en = 0;
    set_m(1, 1, 0, 32'h3000_0000, 32'h0, 4'hF);
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    set_m(1, 0, 0, 32'h0, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    rst = 0;
    chk_quiet();
    ack_man = 1;
    rdata_man = 32'h1234_5678;
    @(posedge clk);
    #1;
    ack_man = 0;
    rdata_man = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("late_ack_m1", {m1_ack, m1_rdata}, 64'h0);
    end
    @(posedge clk);
    #1;
    chk_quiet();
    slave_en = 1;
    glog.delete();
    predict(0, 1, 0, 32'h1000_0000, 32'h0, 4'hF);
    predict(1, 1, 0, 32'h2000_0000, 32'h0, 4'hF);
    fork
      drive(0, 1, 0, 32'h1000_0000, 32'h0, 4'hF, lat0);
      drive(1, 1, 0, 32'h2000_0000, 32'h0, 4'hF, lat1);
    join
    if (glog.size() > 0) chk("rst_tie_first", glog[0], 2'b01);
    else chk("rst_tie_glog_n", glog.size(), 2);

    // Random traffic with random gaps and slave delays.
    fixed_delay = -1;
    fork
      rand_master(0, 40, 3);
      rand_master(1, 40, 3);
    join

    repeat (5) @(posedge clk);
    chk("q_drained", q0.size() + q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
